// File: rtl/riscv_multicycle_cpu.sv
// Multicycle RV32I-subset core: FSM-sequenced datapath behind one ready-handshaked memory port.
// Define RISCV_MC_JUMP_EN to add jal/jalr; otherwise those opcodes halt the core as illegal.
module riscv_multicycle_cpu #(
    parameter int          NUM_REGS = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_pc,
    output logic        o_retire,
    output logic        o_halted,
    output logic [31:0] o_testresult
);
    localparam int         RW      = $clog2(NUM_REGS);
    localparam logic [5:0] NREGS_W = 6'(NUM_REGS);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef RISCV_MC_JUMP_EN
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
`endif

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
    } alu_op_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] ir_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] imm_reg;
    logic [31:0] res_reg;
    logic        retire_reg;
    logic        halted_reg;
    logic [31:0] testresult_reg;
    logic [31:0] regs [NUM_REGS];

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;

    assign opcode = ir_reg[6:0];
    assign rd     = ir_reg[11:7];
    assign funct3 = ir_reg[14:12];
    assign rs1    = ir_reg[19:15];
    assign rs2    = ir_reg[24:20];
    assign funct7 = ir_reg[31:25];

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;

    assign imm_i = {{20{ir_reg[31]}}, ir_reg[31:20]};
    assign imm_s = {{20{ir_reg[31]}}, ir_reg[31:25], ir_reg[11:7]};
    assign imm_b = {{19{ir_reg[31]}}, ir_reg[31], ir_reg[7], ir_reg[30:25], ir_reg[11:8], 1'b0};
    assign imm_j = {{11{ir_reg[31]}}, ir_reg[31], ir_reg[19:12], ir_reg[20], ir_reg[30:21], 1'b0};

    logic        dec_legal;
    alu_op_t     dec_alu_op;
    logic [31:0] dec_imm;
    logic        is_r;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        is_jalr;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        uses_rd;

    // The decode is held stable by ir_reg, so EXECUTE/MEM/WB reuse it without extra state.
    always_comb begin
        dec_legal  = 1'b0;
        dec_alu_op = ALU_ADD;
        dec_imm    = imm_i;
        is_r       = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_branch  = 1'b0;
        is_jump    = 1'b0;
        is_jalr    = 1'b0;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        uses_rd    = 1'b0;
        case (opcode)
            OP_R: begin
                is_r      = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                uses_rd   = 1'b1;
                dec_legal = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: dec_alu_op = ALU_ADD;
                    {7'h20, 3'b000}: dec_alu_op = ALU_SUB;
                    {7'h00, 3'b001}: dec_alu_op = ALU_SLL;
                    {7'h00, 3'b010}: dec_alu_op = ALU_SLT;
                    {7'h00, 3'b100}: dec_alu_op = ALU_XOR;
                    {7'h00, 3'b101}: dec_alu_op = ALU_SRL;
                    {7'h00, 3'b110}: dec_alu_op = ALU_OR;
                    {7'h00, 3'b111}: dec_alu_op = ALU_AND;
                    default:         dec_legal  = 1'b0;
                endcase
            end
            OP_IMM: begin
                uses_rs1  = 1'b1;
                uses_rd   = 1'b1;
                dec_legal = 1'b1;
                case (funct3)
                    3'b000:  dec_alu_op = ALU_ADD;
                    3'b010:  dec_alu_op = ALU_SLT;
                    3'b100:  dec_alu_op = ALU_XOR;
                    3'b110:  dec_alu_op = ALU_OR;
                    3'b111:  dec_alu_op = ALU_AND;
                    default: dec_legal  = 1'b0;
                endcase
            end
            OP_LOAD: begin
                is_load   = 1'b1;
                uses_rs1  = 1'b1;
                uses_rd   = 1'b1;
                dec_legal = (funct3 == 3'b010);
            end
            OP_STORE: begin
                is_store  = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                dec_imm   = imm_s;
                dec_legal = (funct3 == 3'b010);
            end
            OP_BRANCH: begin
                is_branch = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                dec_imm   = imm_b;
                dec_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
            end
`ifdef RISCV_MC_JUMP_EN
            OP_JAL: begin
                is_jump   = 1'b1;
                uses_rd   = 1'b1;
                dec_imm   = imm_j;
                dec_legal = 1'b1;
            end
            OP_JALR: begin
                is_jump   = 1'b1;
                is_jalr   = 1'b1;
                uses_rs1  = 1'b1;
                uses_rd   = 1'b1;
                dec_legal = (funct3 == 3'b000);
            end
`endif
            default: ;
        endcase
        if ((uses_rs1 && ({1'b0, rs1} >= NREGS_W)) ||
            (uses_rs2 && ({1'b0, rs2} >= NREGS_W)) ||
            (uses_rd  && ({1'b0, rd}  >= NREGS_W)))
            dec_legal = 1'b0;
    end

    logic [31:0] alu_b;
    logic [31:0] alu_res;

    assign alu_b = is_r ? b_reg : imm_reg;

    always_comb begin
        alu_res = a_reg + alu_b;
        case (dec_alu_op)
            ALU_ADD: alu_res = a_reg + alu_b;
            ALU_SUB: alu_res = a_reg - alu_b;
            ALU_AND: alu_res = a_reg & alu_b;
            ALU_OR:  alu_res = a_reg | alu_b;
            ALU_XOR: alu_res = a_reg ^ alu_b;
            ALU_SLT: alu_res = {31'd0, $signed(a_reg) < $signed(alu_b)};
            ALU_SLL: alu_res = a_reg << alu_b[4:0];
            ALU_SRL: alu_res = a_reg >> alu_b[4:0];
            default: alu_res = a_reg + alu_b;
        endcase
    end

    logic [31:0] pc_plus_4;
    logic [31:0] pc_plus_imm;
    logic [31:0] jump_target;
    logic        branch_taken;

    assign pc_plus_4    = pc_reg + 32'd4;
    assign pc_plus_imm  = pc_reg + imm_reg;
    assign jump_target  = is_jalr ? (alu_res & ~32'd1) : pc_plus_imm;
    assign branch_taken = funct3[0] ? (a_reg != b_reg) : (a_reg == b_reg);

    // Jump targets park in imm_reg after EXECUTE, since the immediate is no longer needed.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg      <= S_FETCH;
            pc_reg         <= RESET_PC;
            ir_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            imm_reg        <= '0;
            res_reg        <= '0;
            retire_reg     <= 1'b0;
            halted_reg     <= 1'b0;
            testresult_reg <= '0;
        end else begin
            retire_reg <= 1'b0;
            case (state_reg)
                S_FETCH: begin
                    if (i_mem_ready) begin
                        ir_reg    <= i_mem_rdata;
                        state_reg <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_reg   <= regs[rs1[RW-1:0]];
                    b_reg   <= regs[rs2[RW-1:0]];
                    imm_reg <= dec_imm;
                    if (dec_legal) begin
                        state_reg <= S_EXECUTE;
                    end else begin
                        state_reg  <= S_HALT;
                        halted_reg <= 1'b1;
                    end
                end
                S_EXECUTE: begin
                    if (is_branch) begin
                        if (branch_taken && (pc_plus_imm[1:0] != 2'b00)) begin
                            state_reg  <= S_HALT;
                            halted_reg <= 1'b1;
                        end else begin
                            pc_reg     <= branch_taken ? pc_plus_imm : pc_plus_4;
                            retire_reg <= 1'b1;
                            state_reg  <= S_FETCH;
                        end
                    end else if (is_load || is_store) begin
                        if (alu_res[1:0] != 2'b00) begin
                            state_reg  <= S_HALT;
                            halted_reg <= 1'b1;
                        end else begin
                            res_reg   <= alu_res;
                            state_reg <= S_MEM;
                        end
                    end else if (is_jump) begin
                        if (jump_target[1:0] != 2'b00) begin
                            state_reg  <= S_HALT;
                            halted_reg <= 1'b1;
                        end else begin
                            res_reg   <= pc_plus_4;
                            imm_reg   <= jump_target;
                            state_reg <= S_WB;
                        end
                    end else begin
                        res_reg   <= alu_res;
                        state_reg <= S_WB;
                    end
                end
                S_MEM: begin
                    if (i_mem_ready) begin
                        if (is_store) begin
                            pc_reg     <= pc_plus_4;
                            retire_reg <= 1'b1;
                            state_reg  <= S_FETCH;
                        end else begin
                            res_reg   <= i_mem_rdata;
                            state_reg <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (rd != 5'd0)
                        testresult_reg <= res_reg;
                    pc_reg     <= is_jump ? imm_reg : pc_plus_4;
                    retire_reg <= 1'b1;
                    state_reg  <= S_FETCH;
                end
                S_HALT: ;
                default: state_reg <= S_FETCH;
            endcase
        end
    end

    // x0 is never written, so its reset value of zero makes it read as zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if ((state_reg == S_WB) && (rd != 5'd0)) begin
            regs[rd[RW-1:0]] <= res_reg;
        end
    end

    // Request qualifiers come straight from held registers, so they stay stable across wait states.
    assign o_mem_req    = !i_reset && ((state_reg == S_FETCH) || (state_reg == S_MEM));
    assign o_mem_we     = (state_reg == S_MEM) && is_store;
    assign o_mem_addr   = (state_reg == S_MEM) ? {res_reg[31:2], 2'b00} : {pc_reg[31:2], 2'b00};
    assign o_mem_wdata  = b_reg;
    assign o_pc         = pc_reg;
    assign o_retire     = retire_reg;
    assign o_halted     = halted_reg;
    assign o_testresult = testresult_reg;

endmodule

// File: tb/tb_riscv_multicycle_cpu.sv
// Directed bench for riscv_multicycle_cpu: small program snippets against a word memory model.
module tb_riscv_multicycle_cpu;
    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] pc;
    logic        retire;
    logic        halted;
    logic [31:0] tr;

    logic        d16_req;
    logic        d16_we;
    logic [31:0] d16_addr;
    logic [31:0] d16_wdata;
    logic [31:0] d16_pc;
    logic        d16_retire;
    logic        d16_halted;
    logic [31:0] d16_tr;
    logic [31:0] d16_rdata;

    logic [31:0] mem [256];
    int          checks = 0;
    int          errors = 0;
    int          wr_count;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    always #5 clk = ~clk;

    riscv_multicycle_cpu #(.NUM_REGS(32), .RESET_PC(32'h0000_0100)) dut (
        .i_clk(clk), .i_reset(rst),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_ready(ready), .i_mem_rdata(mem_rdata),
        .o_pc(pc), .o_retire(retire), .o_halted(halted), .o_testresult(tr)
    );

    // RV32E instance fed a constant "add x20,x1,x2" on every fetch.
    assign d16_rdata = 32'h0020_8A33;
    riscv_multicycle_cpu #(.NUM_REGS(16), .RESET_PC(32'h0000_0200)) dut16 (
        .i_clk(clk), .i_reset(rst),
        .o_mem_req(d16_req), .o_mem_we(d16_we), .o_mem_addr(d16_addr), .o_mem_wdata(d16_wdata),
        .i_mem_ready(1'b1), .i_mem_rdata(d16_rdata),
        .o_pc(d16_pc), .o_retire(d16_retire), .o_halted(d16_halted), .o_testresult(d16_tr)
    );

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_req && mem_we && ready) begin
            mem[mem_addr[9:2]] = mem_wdata;
            wr_addr = mem_addr;
            wr_data = mem_wdata;
            wr_count = wr_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++)
            mem[i] = 32'h0;
        wr_count = 0;
        wr_addr  = 32'h0;
        wr_data  = 32'h0;
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        mem[addr[9:2]] = word;
    endtask

    task automatic run_until_retire(input int max_cycles, output int n);
        n = -1;
        for (int i = 1; i <= max_cycles; i++) begin
            tick();
            if (retire) begin
                n = i;
                break;
            end
        end
        $display("retire: pc=%h testresult=%h cycles=%0d", pc, tr, n);
    endtask

    task automatic test_reset();
        int n;
        clear_mem();
        put(32'h100, 32'h0050_0093);   // addi x1,x0,5
        ready = 1'b1;
        rst   = 1'b1;
        tick();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mem_req); end
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL reset_pc: got %h expected 00000100", pc); end
        checks++; if (retire !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_flags: got retire=%b halted=%b expected 0/0", retire, halted); end
        checks++; if (tr !== 32'h0) begin errors++; $display("FAIL reset_testresult: got %h expected 00000000", tr); end
        rst = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin errors++; $display("FAIL first_fetch: got req=%b we=%b addr=%h expected 1/0/00000100", mem_req, mem_we, mem_addr); end
        run_until_retire(20, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL addi_latency: got %0d expected 4", n); end
        checks++; if (tr !== 32'd5) begin errors++; $display("FAIL addi_result: got %h expected 00000005", tr); end
        checks++; if (pc !== 32'h104) begin errors++; $display("FAIL addi_pc: got %h expected 00000104", pc); end
        tick();
        checks++; if (retire !== 1'b0) begin errors++; $display("FAIL retire_pulse: got %b expected 0", retire); end
    endtask

    task automatic test_back_to_back();
        int n;
        clear_mem();
        put(32'h100, 32'h0070_0093);   // addi x1,x0,7
        put(32'h104, 32'hFFD0_0113);   // addi x2,x0,-3
        put(32'h108, 32'h0020_81B3);   // add  x3,x1,x2
        put(32'h10C, 32'h0030_2423);   // sw   x3,8(x0)
        put(32'h110, 32'h0080_2203);   // lw   x4,8(x0)
        put(32'h114, 32'h0042_02B3);   // add  x5,x4,x4
        ready = 1'b1;
        do_reset();
        run_until_retire(20, n);
        run_until_retire(20, n);
        run_until_retire(20, n);
        checks++; if (tr !== 32'd4) begin errors++; $display("FAIL add_result: got %h expected 00000004", tr); end
        run_until_retire(20, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL sw_latency: got %0d expected 4", n); end
        checks++; if (wr_count !== 1 || wr_addr !== 32'h8 || wr_data !== 32'h4) begin errors++; $display("FAIL sw_write: got count=%0d addr=%h data=%h expected 1/00000008/00000004", wr_count, wr_addr, wr_data); end
        run_until_retire(20, n);
        checks++; if (n !== 5) begin errors++; $display("FAIL lw_latency: got %0d expected 5", n); end
        checks++; if (tr !== 32'd4) begin errors++; $display("FAIL lw_result: got %h expected 00000004", tr); end
        run_until_retire(20, n);
        checks++; if (tr !== 32'd8) begin errors++; $display("FAIL lw_use: got %h expected 00000008", tr); end
        checks++; if (pc !== 32'h118) begin errors++; $display("FAIL seq_pc: got %h expected 00000118", pc); end
    endtask

    task automatic test_alu_ops();
        logic [31:0] prog [16];
        logic [31:0] expv [16];
        int n;
        prog[0]  = 32'h0070_0093; expv[0]  = 32'h0000_0007;  // addi x1,x0,7
        prog[1]  = 32'hFFD0_0113; expv[1]  = 32'hFFFF_FFFD;  // addi x2,x0,-3
        prog[2]  = 32'h4020_82B3; expv[2]  = 32'h0000_000A;  // sub  x5,x1,x2
        prog[3]  = 32'h0020_F2B3; expv[3]  = 32'h0000_0005;  // and
        prog[4]  = 32'h0020_E2B3; expv[4]  = 32'hFFFF_FFFF;  // or
        prog[5]  = 32'h0020_C2B3; expv[5]  = 32'hFFFF_FFFA;  // xor
        prog[6]  = 32'h0020_A2B3; expv[6]  = 32'h0000_0000;  // slt x5,x1,x2
        prog[7]  = 32'h0011_22B3; expv[7]  = 32'h0000_0001;  // slt x5,x2,x1
        prog[8]  = 32'h0020_92B3; expv[8]  = 32'hE000_0000;  // sll x5,x1,x2 (shift 29)
        prog[9]  = 32'h0011_52B3; expv[9]  = 32'h01FF_FFFF;  // srl x5,x2,x1
        prog[10] = 32'hFFF1_2313; expv[10] = 32'h0000_0001;  // slti x6,x2,-1
        prog[11] = 32'h0F01_4313; expv[11] = 32'hFFFF_FF0D;  // xori x6,x2,0xF0
        prog[12] = 32'h1000_E313; expv[12] = 32'h0000_0107;  // ori  x6,x1,0x100
        prog[13] = 32'h7F01_7313; expv[13] = 32'h0000_07F0;  // andi x6,x2,0x7F0
        prog[14] = 32'h0090_8013; expv[14] = 32'h0000_07F0;  // addi x0,x1,9 (dropped)
        prog[15] = 32'h0010_03B3; expv[15] = 32'h0000_0007;  // add  x7,x0,x1
        clear_mem();
        for (int i = 0; i < 16; i++)
            put(32'h100 + 32'(4 * i), prog[i]);
        ready = 1'b1;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            run_until_retire(20, n);
            checks++; if (tr !== expv[i]) begin errors++; $display("FAIL alu_%0d: got %h expected %h", i, tr, expv[i]); end
        end
    endtask

    task automatic test_wait_states();
        int n;
        clear_mem();
        put(32'h100, 32'h0090_0093);   // addi x1,x0,9
        ready = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin errors++; $display("FAIL wait_hold_%0d: got req=%b we=%b addr=%h expected 1/0/00000100", k, mem_req, mem_we, mem_addr); end
            if (k < 3) tick();
        end
        ready = 1'b1;
        tick();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL req_drop: got %b expected 0", mem_req); end
        run_until_retire(20, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL wait_latency: got %0d expected 3 (7 total)", n); end
        checks++; if (tr !== 32'd9) begin errors++; $display("FAIL wait_result: got %h expected 00000009", tr); end
    endtask

    task automatic test_branches();
        int n;
        clear_mem();
        put(32'h100, 32'hFE00_0CE3);   // beq x0,x0,-8
        ready = 1'b1;
        do_reset();
        run_until_retire(20, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL beq_latency: got %0d expected 3", n); end
        checks++; if (pc !== 32'hF8) begin errors++; $display("FAIL beq_pc: got %h expected 000000f8", pc); end
        tick();
        checks++; if (retire !== 1'b0) begin errors++; $display("FAIL beq_retire_once: got %b expected 0", retire); end

        put(32'h100, 32'hFE00_1CE3);   // bne x0,x0,-8
        do_reset();
        run_until_retire(20, n);
        checks++; if (n !== 3 || pc !== 32'h104) begin errors++; $display("FAIL bne_pc: got cycles=%0d pc=%h expected 3/00000104", n, pc); end

        put(32'h100, 32'h0000_0363);   // beq x0,x0,+6 -> misaligned target
        do_reset();
        tick(); tick(); tick();
        checks++; if (halted !== 1'b1 || pc !== 32'h100 || retire !== 1'b0) begin errors++; $display("FAIL br_misalign: got halted=%b pc=%h retire=%b expected 1/00000100/0", halted, pc, retire); end

        put(32'h100, 32'h0000_1363);   // bne x0,x0,+6 -> not taken, no halt
        do_reset();
        run_until_retire(20, n);
        checks++; if (halted !== 1'b0 || pc !== 32'h104) begin errors++; $display("FAIL br_nottaken_misalign: got halted=%b pc=%h expected 0/00000104", halted, pc); end
    endtask

    task automatic test_halt();
        clear_mem();
        put(32'h100, 32'h0000_007F);   // illegal opcode
        ready = 1'b1;
        do_reset();
        tick(); tick();
        checks++; if (halted !== 1'b1 || pc !== 32'h100) begin errors++; $display("FAIL halt_opcode: got halted=%b pc=%h expected 1/00000100", halted, pc); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (mem_req !== 1'b0 || retire !== 1'b0 || pc !== 32'h100) begin errors++; $display("FAIL halt_frozen_%0d: got req=%b retire=%b pc=%h expected 0/0/00000100", k, mem_req, retire, pc); end
        end
        do_reset();
        checks++; if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL halt_recover: got halted=%b req=%b addr=%h expected 0/1/00000100", halted, mem_req, mem_addr); end

        put(32'h100, 32'h4020_D2B3);   // sra: unsupported funct
        do_reset();
        tick(); tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_funct: got %b expected 1", halted); end

        put(32'h100, 32'h0060_2203);   // lw x4,6(x0)
        do_reset();
        tick(); tick();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL lw_mis_decode: got %b expected 0", halted); end
        tick();
        checks++; if (halted !== 1'b1 || pc !== 32'h100 || mem_req !== 1'b0) begin errors++; $display("FAIL lw_misalign: got halted=%b pc=%h req=%b expected 1/00000100/0", halted, pc, mem_req); end
    endtask

    task automatic test_regs16();
        int n;
        clear_mem();
        put(32'h100, 32'h0020_8A33);   // add x20,x1,x2
        ready = 1'b1;
        do_reset();
        tick(); tick();
        checks++; if (d16_halted !== 1'b1 || d16_pc !== 32'h200 || d16_req !== 1'b0) begin errors++; $display("FAIL rv32e_halt: got halted=%b pc=%h req=%b expected 1/00000200/0", d16_halted, d16_pc, d16_req); end
        run_until_retire(20, n);
        checks++; if (halted !== 1'b0 || n !== 2) begin errors++; $display("FAIL rv32i_x20: got halted=%b remaining=%0d expected 0/2", halted, n); end
    endtask

    task automatic test_jump();
        int n;
        clear_mem();
        put(32'h100, 32'h0100_00EF);   // jal x1,+16
        put(32'h110, 32'h0010_82E7);   // jalr x5,1(x1)
        ready = 1'b1;
        do_reset();
`ifdef RISCV_MC_JUMP_EN
        run_until_retire(20, n);
        checks++; if (n !== 4 || tr !== 32'h104 || pc !== 32'h110) begin errors++; $display("FAIL jal: got cycles=%0d tr=%h pc=%h expected 4/00000104/00000110", n, tr, pc); end
        run_until_retire(20, n);
        checks++; if (tr !== 32'h114 || pc !== 32'h104) begin errors++; $display("FAIL jalr: got tr=%h pc=%h expected 00000114/00000104", tr, pc); end
`else
        n = 0;
        tick(); tick();
        checks++; if (halted !== 1'b1 || pc !== 32'h100 || retire !== 1'b0) begin errors++; $display("FAIL jal_disabled: got halted=%b pc=%h retire=%b expected 1/00000100/0 (n=%0d)", halted, pc, retire, n); end
`endif
    endtask

    initial begin
        rst   = 1'b1;
        ready = 1'b1;
        clear_mem();
        test_reset();
        test_back_to_back();
        test_alu_ops();
        test_wait_states();
        test_branches();
        test_halt();
        test_regs16();
        test_jump();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
